// File: rtl/prewish5k_pkg.sv
// Shared constants and types for the blinky pattern arbiter.
// Imported by the round-robin picker and the arbiter top.
package prewish5k_pkg;

  localparam int NUM_REQ = 4;
  localparam int MASK_W  = 8;

  localparam logic [MASK_W-1:0] IDLE_MASK_DEF = 8'h00;

  typedef enum logic {
    ST_IDLE,
    ST_DWELL
  } state_t;

endpackage

// File: rtl/prewish5k_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, modulo NUM_REQ.
// Kept standalone so the scan order can be exercised on its own.
module prewish5k_rr_pick
  import prewish5k_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic               valid,
  output logic [1:0]         win
);

  logic [1:0] idx;

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    valid = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        valid = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/prewish5k_blink_arbiter.sv
// Round-robin sharing of one blinky pattern engine among four requesters,
// with a minimum dwell per granted pattern and an idle pattern when released.
module prewish5k_blink_arbiter
  import prewish5k_pkg::*;
#(
  parameter int                NUM_REQ_P    = prewish5k_pkg::NUM_REQ,
  parameter int                DWELL_CYCLES = 33554432,
  parameter logic [MASK_W-1:0] IDLE_MASK    = IDLE_MASK_DEF
) (
  input  logic                        CLK_I,
  input  logic                        RST_I,
  input  logic [NUM_REQ_P-1:0]        i_req,
  input  logic [NUM_REQ_P*MASK_W-1:0] i_masks,
  output logic                        o_stb,
  output logic [MASK_W-1:0]           o_dat,
  output logic [NUM_REQ_P-1:0]        o_ack,
  output logic [NUM_REQ_P-1:0]        o_grant,
  output logic                        o_busy
);

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [1:0]            ptr, ptr_nxt;
  logic                  stb_nxt, busy_nxt;
  logic [MASK_W-1:0]     dat_nxt, mask_w;
  logic [NUM_REQ_P-1:0]  ack_nxt, grant_nxt, win_oh;
  logic                  pick_valid;
  logic [1:0]            pick_win;

  prewish5k_rr_pick u_pick (
    .req   (i_req),
    .ptr   (ptr),
    .valid (pick_valid),
    .win   (pick_win)
  );

  assign mask_w = i_masks[int'(pick_win)*MASK_W +: MASK_W];
  assign win_oh = NUM_REQ_P'(1) << pick_win;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ptr     <= '0;
      o_stb   <= 1'b0;
      o_dat   <= '0;
      o_ack   <= '0;
      o_grant <= '0;
      o_busy  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ptr     <= ptr_nxt;
      o_stb   <= stb_nxt;
      o_dat   <= dat_nxt;
      o_ack   <= ack_nxt;
      o_grant <= grant_nxt;
      o_busy  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_valid) state_nxt = ST_DWELL;
      ST_DWELL: if (cnt == '0)  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stb_nxt   = 1'b0;
    ack_nxt   = '0;
    dat_nxt   = o_dat;
    grant_nxt = o_grant;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    busy_nxt  = (state_nxt == ST_DWELL);
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          ack_nxt   = win_oh;
          grant_nxt = win_oh;
          ptr_nxt   = pick_win + 2'd1;
          cnt_nxt   = CNT_LOAD;
          // Re-granting the same owner with an unchanged mask must not restart the blinky phase.
          if (!(o_grant == win_oh && mask_w == o_dat)) begin
            stb_nxt = 1'b1;
            dat_nxt = mask_w;
          end
        end else if (o_grant != '0) begin
          stb_nxt   = 1'b1;
          dat_nxt   = IDLE_MASK;
          grant_nxt = '0;
        end
      end
      ST_DWELL: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prewish5k_blink_arbiter.sv
// Directed and randomized checks of the blinky arbiter with a 4-cycle dwell,
// the random part scored against an edge-by-edge behavioural model.
module tb_prewish5k_blink_arbiter;

  localparam int DW = 4;
  localparam logic [7:0] IDLE = 8'h00;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [3:0]  i_req = '0;
  logic [31:0] i_masks = '0;
  logic        o_stb, o_busy;
  logic [7:0]  o_dat;
  logic [3:0]  o_ack, o_grant;

  int n_checks = 0;
  int n_fail   = 0;

  prewish5k_blink_arbiter #(
    .NUM_REQ_P    (4),
    .DWELL_CYCLES (DW),
    .IDLE_MASK    (IDLE)
  ) dut (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .i_req   (i_req),
    .i_masks (i_masks),
    .o_stb   (o_stb),
    .o_dat   (o_dat),
    .o_ack   (o_ack),
    .o_grant (o_grant),
    .o_busy  (o_busy)
  );

  always #5 CLK_I = ~CLK_I;

  // Reference model state: integers and edge numbers, no FSM encoding.
  int         m_ptr, m_owner, m_last, m_next, m_edge;
  logic [7:0] m_dat;
  logic       e_stb, e_busy;
  logic [7:0] e_dat;
  logic [3:0] e_ack, e_grant;

  task automatic step();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic do_reset();
    i_req   = '0;
    i_masks = '0;
    RST_I   = 1'b1;
    repeat (2) @(posedge CLK_I);
    #1;
    RST_I   = 1'b0;
  endtask

  task automatic model_init();
    m_ptr = 0; m_owner = -1; m_last = -100; m_next = 0; m_edge = 0; m_dat = 8'h00;
  endtask

  // Expected outputs after the coming edge, given the inputs presented to it.
  task automatic model_edge(input logic [3:0] req, input logic [31:0] masks);
    int w;
    logic [7:0] mk;
    e_stb = 1'b0;
    e_ack = '0;
    w = -1;
    if (m_edge >= m_next) begin
      for (int i = 0; i < 4; i++)
        if (w < 0 && req[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
      if (w >= 0) begin
        mk = masks[w*8 +: 8];
        e_ack = 4'(1 << w);
        if (!(m_owner == w && mk == m_dat)) begin
          e_stb = 1'b1;
          m_dat = mk;
        end
        m_owner = w;
        m_ptr   = (w + 1) % 4;
        m_last  = m_edge;
        m_next  = m_edge + DW + 1;
      end else if (m_owner >= 0) begin
        e_stb   = 1'b1;
        m_dat   = IDLE;
        m_owner = -1;
      end
    end
    e_busy  = (m_edge - m_last) < DW;
    e_grant = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
    e_dat   = m_dat;
    m_edge++;
  endtask

  task automatic test_reset();
    do_reset();
    RST_I = 1'b1;
    #1;
    n_checks++;
    if ({o_stb, o_dat, o_ack, o_grant, o_busy} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_values: got stb=%b dat=%h ack=%b grant=%b busy=%b, want all 0",
               o_stb, o_dat, o_ack, o_grant, o_busy);
    end
    RST_I = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    i_req = 4'b0001;
    i_masks[7:0] = 8'hA0;
    step();
    n_checks++;
    if ({o_stb, o_dat, o_ack, o_grant, o_busy} !== {1'b1, 8'hA0, 4'b0001, 4'b0001, 1'b1}) begin
      n_fail++;
      $display("FAIL single_grant: got stb=%b dat=%h ack=%b grant=%b busy=%b, want 1 a0 0001 0001 1",
               o_stb, o_dat, o_ack, o_grant, o_busy);
    end
    i_req = '0;
    for (int c = 1; c <= DW; c++) begin
      step();
      n_checks++;
      if ({o_busy, o_stb, o_ack} !== {(c < DW), 1'b0, 4'b0000}) begin
        n_fail++;
        $display("FAIL single_busy[%0d]: got busy=%b stb=%b ack=%b, want busy=%b stb=0 ack=0000",
                 c, o_busy, o_stb, o_ack, (c < DW));
      end
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int got, cyc, last;
    do_reset();
    i_masks = 32'h44332211;
    i_req   = 4'b1111;
    got = 0; cyc = 0; last = 0;
    while (got < 5 && cyc < 40) begin
      step();
      cyc++;
      if (o_ack != 4'b0) begin
        n_checks++;
        if ({o_ack, o_stb, o_dat} !== {4'(1 << order[got]), 1'b1, 8'(8'h11 * (order[got] + 1))}) begin
          n_fail++;
          $display("FAIL rr_grant[%0d]: got ack=%b stb=%b dat=%h, want requester %0d",
                   got, o_ack, o_stb, o_dat, order[got]);
        end
        if (got > 0) begin
          n_checks++;
          if (cyc - last != DW + 1) begin
            n_fail++;
            $display("FAIL rr_spacing[%0d]: got %0d cycles, want %0d", got, cyc - last, DW + 1);
          end
        end
        last = cyc;
        got++;
      end
    end
    i_req = '0;
    n_checks++;
    if (got != 5) begin
      n_fail++;
      $display("FAIL rr_timeout: got %0d grants, want 5", got);
    end
  endtask

  task automatic test_same_pattern_skip();
    do_reset();
    i_masks[7:0] = 8'hA0;
    i_req = 4'b0001;
    step();
    repeat (DW + 1) step();
    n_checks++;
    if ({o_ack, o_stb, o_dat, o_grant} !== {4'b0001, 1'b0, 8'hA0, 4'b0001}) begin
      n_fail++;
      $display("FAIL same_skip: got ack=%b stb=%b dat=%h grant=%b, want 0001 0 a0 0001",
               o_ack, o_stb, o_dat, o_grant);
    end
    i_req = '0;
  endtask

  task automatic test_idle_release();
    do_reset();
    i_masks[7:0] = 8'h5C;
    i_req = 4'b0001;
    step();
    i_req = '0;
    repeat (DW) step();
    n_checks++;
    if ({o_stb, o_grant, o_busy} !== {1'b0, 4'b0001, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_pre: got stb=%b grant=%b busy=%b, want 0 0001 0", o_stb, o_grant, o_busy);
    end
    step();
    n_checks++;
    if ({o_stb, o_dat, o_grant} !== {1'b1, IDLE, 4'b0000}) begin
      n_fail++;
      $display("FAIL idle_release: got stb=%b dat=%h grant=%b, want 1 00 0000", o_stb, o_dat, o_grant);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (o_stb !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_quiet[%0d]: got stb=%b, want 0", c, o_stb);
      end
    end
  endtask

  task automatic test_request_during_dwell();
    do_reset();
    i_masks = 32'h0077_0055;
    i_req = 4'b0001;
    step();
    i_req = 4'b0100;
    for (int c = 1; c <= DW + 1; c++) begin
      step();
      n_checks++;
      if (o_ack !== ((c == DW + 1) ? 4'b0100 : 4'b0000)) begin
        n_fail++;
        $display("FAIL dwell_req[%0d]: got ack=%b, want %b", c, o_ack,
                 (c == DW + 1) ? 4'b0100 : 4'b0000);
      end
    end
    n_checks++;
    if ({o_stb, o_dat} !== {1'b1, 8'h77}) begin
      n_fail++;
      $display("FAIL dwell_req_load: got stb=%b dat=%h, want 1 77", o_stb, o_dat);
    end
    i_req = '0;
  endtask

  task automatic test_reset_mid_dwell();
    do_reset();
    i_masks = 32'h0000_9966;
    i_req = 4'b0001;
    step();
    i_req = '0;
    step();
    #2;
    RST_I = 1'b1;
    #1;
    n_checks++;
    if ({o_stb, o_dat, o_ack, o_grant, o_busy} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got stb=%b dat=%h ack=%b grant=%b busy=%b, want all 0",
               o_stb, o_dat, o_ack, o_grant, o_busy);
    end
    i_req = 4'b0010;
    step();
    RST_I = 1'b0;
    step();
    n_checks++;
    if ({o_ack, o_grant, o_stb, o_dat} !== {4'b0010, 4'b0010, 1'b1, 8'h99}) begin
      n_fail++;
      $display("FAIL reset_regrant: got ack=%b grant=%b stb=%b dat=%h, want 0010 0010 1 99",
               o_ack, o_grant, o_stb, o_dat);
    end
    i_req = '0;
  endtask

  task automatic test_random();
    do_reset();
    model_init();
    for (int cyc = 0; cyc < 400; cyc++) begin
      model_edge(i_req, i_masks);
      step();
      n_checks++;
      if ({o_stb, o_dat, o_ack, o_grant, o_busy} !== {e_stb, e_dat, e_ack, e_grant, e_busy}) begin
        n_fail++;
        $display("FAIL random[%0d]: got stb=%b dat=%h ack=%b grant=%b busy=%b, want stb=%b dat=%h ack=%b grant=%b busy=%b",
                 cyc, o_stb, o_dat, o_ack, o_grant, o_busy, e_stb, e_dat, e_ack, e_grant, e_busy);
      end
      for (int n = 0; n < 4; n++) begin
        if (i_req[n]) begin
          if (e_ack[n]) begin
            if ($urandom_range(0, 1) == 0) i_req[n] = 1'b0;
          end else if ($urandom_range(0, 99) < 3) begin
            i_req[n] = 1'b0;
          end
        end else if ($urandom_range(0, 99) < 15) begin
          i_masks[n*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'hA0 : 8'($urandom);
          i_req[n] = 1'b1;
        end
      end
    end
    i_req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_same_pattern_skip();
    test_idle_release();
    test_request_during_dwell();
    test_reset_mid_dwell();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prewish5k_blink_arbiter.md
# prewish5k_blink_arbiter

Shares the single `prewish5k_blinky` LED pattern engine among four requesters, such as a heartbeat, an error reporter, a debug source and a boot-status source. The block grants the engine round-robin and writes the winner's 8-bit mask with a one-cycle strobe on the blinky's `STB_I`/`DAT_I`. It then holds that pattern for a minimum dwell before re-arbitrating. When no requester remains, it loads an idle pattern. It sits between the requesting logic and the blinky instance in the top level.

## Interface
- `NUM_REQ`, 4: number of requesters; fixed at 4 in this revision.
- `DWELL_CYCLES`, 33554432: minimum cycles a granted pattern stays loaded. The default is one full 8-bit rotation at the blinky's 2^22 divider. Must be ≥ 1.
- `IDLE_MASK`, 8'h00: pattern loaded when the last owner is released and no request is pending.

Ports:
- `CLK_I` in 1: system clock; all logic on rising edge.
- `RST_I` in 1: reset; asynchronous, active-high.
- `i_req` in 4: level request per requester; held until the matching `o_ack` pulse.
- `i_masks` in 32: requester *n* mask on bits [8n+7:8n]; must be stable while `i_req[n]` is high.
- `o_stb` out 1: one-cycle load strobe to the blinky `STB_I`.
- `o_dat` out 8: mask to the blinky `DAT_I`; holds the last loaded value.
- `o_ack` out 4: one-cycle grant pulse to the winning requester.
- `o_grant` out 4: one-hot current owner; 0 when idle-owned.
- `o_busy` out 1: high while in DWELL.

## Operation
- **Reset values.** State IDLE; `o_stb`=0, `o_dat`=0, `o_ack`=0, `o_grant`=0, `o_busy`=0, RR pointer=0, dwell counter=0.
- **IDLE, some `i_req` high.**
  - Winner *w* is the first set request scanning from the pointer upward, modulo 4.
  - Next edge registers: `o_ack[w]`=1, `o_grant`=onehot(w), pointer=(w+1) mod 4, counter=DWELL_CYCLES−1, state→DWELL.
  - `o_stb`=1 and `o_dat`=mask_w, unless `o_grant`==onehot(w) already and mask_w==`o_dat`. In that case `o_stb` stays 0, so the blinky phase is not disturbed, but `o_ack` still pulses.
- **IDLE, no request, `o_grant`≠0.** Next edge registers `o_stb`=1, `o_dat`=IDLE_MASK, `o_grant`=0; state stays IDLE.
- **IDLE, no request, `o_grant`=0.** Outputs hold; `o_stb`=0.
- **DWELL.** `o_busy`=1; all requests are ignored; the counter decrements each cycle. Counter==0 with state DWELL → IDLE on the next edge.
- **Requester behaviour.** A requester still requesting after its ack competes again. Round-robin guarantees every other pending requester is served first.
- **Early drop.** A requester that drops `i_req` before its ack is simply not granted; there is no error.
- **Reset mid-DWELL.** All outputs clear immediately. The first arbitration happens on the first edge after `RST_I` deasserts with a request present.

## Timing
- **Grant latency.** 1 cycle: a request sampled at edge *k* in IDLE gives `o_stb`/`o_ack` high between edges *k* and *k*+1.
- **Strobe spacing.** Minimum between requester strobes is DWELL_CYCLES+1 cycles.
- **Pulse widths.** `o_stb` and `o_ack` are never high for 2 consecutive cycles.
- **Busy window.** `o_busy` rises with the ack cycle and falls the cycle the state returns to IDLE; it is high for exactly DWELL_CYCLES cycles.
- **Counter width.** $clog2(DWELL_CYCLES+1); no wrap is permitted.
- **Registered outputs.** All outputs are registered; no combinational path from `i_req` to any output.

## Structure
- **Package `prewish5k_pkg`.**
  - `NUM_REQ` and `MASK_W`=8.
  - The state enum {ST_IDLE, ST_DWELL}.
  - The default IDLE_MASK constant.
- **Sub-module `prewish5k_rr_pick`.** Combinational picker taking a 4-bit request vector and a 2-bit pointer. It outputs a valid flag and a 2-bit winner index, so the picker can be unit-tested alone.
- **Arbiter.** Holds the FSM, dwell counter, pointer and output registers.

## Test plan
All scenarios use DWELL_CYCLES=4 and IDLE_MASK=8'h00.
- **Single request.** After reset, raise `i_req`=0001 with mask0=8'hA0. One cycle later: `o_stb`=1, `o_dat`=A0, `o_ack`=0001, `o_grant`=0001; `o_busy` high for 4 cycles.
- **Round-robin order.** Hold `i_req`=1111 continuously with masks 11/22/33/44. Grant order is 0,1,2,3,0 with strobes exactly 5 cycles apart.
- **Same-pattern skip.** Only req0 is held, mask A0. The second grant gives `o_ack`=0001 with `o_stb`=0, and `o_dat` stays A0.
- **Idle release.** Req0 is granted and then dropped. After DWELL the next cycle gives `o_stb`=1, `o_dat`=00, `o_grant`=0000; no further strobes follow.
- **Request during DWELL.** Raise req2 mid-DWELL while req0 owns. Req2 is not acked until the cycle after the counter reaches 0.
- **Reset mid-DWELL.** Assert `RST_I` asynchronously mid-DWELL. All outputs go 0 before the next clock edge. After release with req1 high, the first edge grants requester 1.
